// File: rtl/regfile_param_dump.sv
// regfile_param_dump: parametrised register file with optional bypass and a handshaked dump sequencer
module regfile_param_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Rs1_addr,
  input  logic [ADDR_W-1:0] Rs2_addr,
  input  logic [ADDR_W-1:0] Wt_addr,
  input  logic [DATA_W-1:0] Wt_data,
  output logic [DATA_W-1:0] Rs1_data,
  output logic [DATA_W-1:0] Rs2_data,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_en;
  logic [ADDR_W-1:0] nxt_addr, ld_addr;
  logic [DATA_W-1:0] ld_data;
  // Writes to entry 0 are dropped when it is hardwired to zero
  assign wr_en = RegWrite && !(ZERO_REG && Wt_addr == '0);
  // Read ports and the value the next dump beat must carry (entry contents after this edge)
  always_comb begin
    Rs1_data = (ZERO_REG && Rs1_addr == '0) ? '0 : (BYPASS && wr_en && Rs1_addr == Wt_addr) ? Wt_data : mem[Rs1_addr];
    Rs2_data = (ZERO_REG && Rs2_addr == '0) ? '0 : (BYPASS && wr_en && Rs2_addr == Wt_addr) ? Wt_data : mem[Rs2_addr];
    nxt_addr = dump_addr + ADDR_W'(1);
    ld_addr = (state == IDLE) ? '0 : nxt_addr;
    ld_data = (ZERO_REG && ld_addr == '0) ? '0 : (wr_en && ld_addr == Wt_addr) ? Wt_data : mem[ld_addr];
  end
  // Storage array, cleared on reset
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr_en) mem[Wt_addr] <= Wt_data;
  // Dump sequencer: load entry, hold until accepted, advance, pulse done after the last beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      dump_valid <= 1'b0;
      dump_busy <= 1'b0;
      dump_done <= 1'b0;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: if (dump_start) begin
          state <= STREAM;
          dump_valid <= 1'b1;
          dump_busy <= 1'b1;
          dump_addr <= '0;
          dump_data <= ld_data;
        end
        STREAM: if (dump_ready) begin
          if (dump_addr == LAST) begin
            state <= DONE;
            dump_valid <= 1'b0;
            dump_done <= 1'b1;
          end else begin
            dump_addr <= nxt_addr;
            dump_data <= ld_data;
          end
        end
        default: begin
          state <= IDLE;
          dump_busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_regfile_param_dump.sv
// tb_regfile_param_dump: directed stimulus checked against a transaction-level model of the register file and dump
module tb_regfile_param_dump;
  logic clk = 0;
  logic rst = 0;
  logic RegWrite = 0;
  logic [4:0] Rs1_addr = 0, Rs2_addr = 0, Wt_addr = 0;
  logic [31:0] Wt_data = 0;
  logic [31:0] Rs1_data, Rs2_data, nb_rs1, nb_rs2;
  logic dump_start = 0, dump_ready = 0;
  logic dump_valid, dump_busy, dump_done, nb_valid, nb_busy, nb_done;
  logic [4:0] dump_addr, nb_addr;
  logic [31:0] dump_data, nb_data;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  logic [31:0] m_mem [32];
  bit m_valid, m_busy, m_done;
  int m_idx;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  regfile_param_dump dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
    .Wt_addr(Wt_addr), .Wt_data(Wt_data), .Rs1_data(Rs1_data), .Rs2_data(Rs2_data),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  regfile_param_dump #(.BYPASS(1'b0)) nb (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
    .Wt_addr(Wt_addr), .Wt_data(Wt_data), .Rs1_data(nb_rs1), .Rs2_data(nb_rs2),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(nb_valid),
    .dump_addr(nb_addr), .dump_data(nb_data), .dump_busy(nb_busy), .dump_done(nb_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && RegWrite && Wt_addr == a) return Wt_data;
    return m_mem[a];
  endfunction

  // Model: a dump is a sequence of 32 beats; beat k carries entry k as it stood when the previous beat was accepted
  always @(posedge clk or posedge rst)
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_valid = 0; m_busy = 0; m_done = 0; m_idx = 0; m_data = 0;
    end else begin
      if (RegWrite && Wt_addr != 0) m_mem[Wt_addr] = Wt_data;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_valid && dump_ready) begin
        if (m_idx == 31) begin m_valid = 0; m_done = 1; end
        else begin m_idx++; m_data = m_mem[m_idx]; end
      end else if (!m_busy && dump_start) begin
        m_busy = 1; m_valid = 1; m_idx = 0; m_data = m_mem[0];
      end
    end

  always @(negedge clk) if (chk_en) begin
    chk("rs1", Rs1_data, mread(Rs1_addr, 1));
    chk("rs2", Rs2_data, mread(Rs2_addr, 1));
    chk("nb_rs1", nb_rs1, mread(Rs1_addr, 0));
    chk("nb_rs2", nb_rs2, mread(Rs2_addr, 0));
    chk("valid", dump_valid, m_valid);
    chk("busy", dump_busy, m_busy);
    chk("done", dump_done, m_done);
    if (m_valid) begin
      chk("dump_addr", dump_addr, m_idx);
      chk("dump_data", dump_data, m_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1; Wt_addr = a; Wt_data = d;
    tick;
    RegWrite = 0;
  endtask

  initial begin
    int beats, ndone, done_cyc, seen9, found;
    bit got, wrote;
    #1 rst = 1;
    #2;
    chk("rst_valid", dump_valid, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_addr", dump_addr, 0);
    chk("rst_data", dump_data, 0);
    tick; tick;
    rst = 0;
    chk_en = 1;
    tick;
    // bypass on a fresh file: old value of entry 5 is 0
    RegWrite = 1; Wt_addr = 5; Wt_data = 32'hDEAD_BEEF; Rs1_addr = 5; Rs2_addr = 5;
    #2;
    chk("byp_rs1", Rs1_data, 32'hDEAD_BEEF);
    chk("byp_rs2", Rs2_data, 32'hDEAD_BEEF);
    chk("nobyp_rs1", nb_rs1, 32'h0);
    chk("nobyp_rs2", nb_rs2, 32'h0);
    tick;
    RegWrite = 0;
    for (int k = 1; k < 32; k++) wr(5'(k), 32'hA5A5_0000 + k);
    for (int k = 0; k < 32; k++) begin
      Rs1_addr = 5'(k); Rs2_addr = 5'(31 - k);
      #2;
      chk("readback1", Rs1_data, k == 0 ? 32'h0 : 32'hA5A5_0000 + k);
      chk("readback2", Rs2_data, k == 31 ? 32'h0 : 32'hA5A5_0000 + 31 - k);
      tick;
    end
    wr(5'd0, 32'h1234_5678);
    Rs1_addr = 0;
    #2 chk("zero_reg", Rs1_data, 32'h0);
    tick;
    // dump with constant ready
    beats = 0; ndone = 0; done_cyc = 0;
    dump_ready = 1; dump_start = 1;
    for (int c = 1; c <= 36; c++) begin
      #2;
      if (dump_valid) beats++;
      if (dump_done) begin ndone++; done_cyc = c; end
      if (c == 2) chk("first_beat", dump_data, 32'h0);
      if (c == 5) chk("beat3", dump_data, 32'hA5A5_0003);
      if (c == 34) chk("busy_in_done", dump_busy, 1);
      if (c == 35) chk("busy_fall", dump_busy, 0);
      tick;
      dump_start = 0;
    end
    chk("beats", beats, 32);
    chk("done_count", ndone, 1);
    chk("done_cycle", done_cyc, 34);
    // backpressure, mid-stream start, concurrent writes while stalled on beat 7
    dump_ready = 0; dump_start = 1;
    tick;
    dump_start = 0; got = 0; wrote = 0; seen9 = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      dump_ready = c[0];
      dump_start = (c == 10);
      if (dump_valid && dump_addr == 7 && !wrote) begin
        dump_ready = 0; dump_start = 0;
        wr(5'd7, 32'h1);
        wr(5'd9, 32'h2);
        wrote = 1;
        dump_ready = 1;
      end
      #2;
      if (dump_valid && dump_ready && dump_addr == 7) chk("beat7_old", dump_data, 32'hA5A5_0007);
      if (dump_valid && dump_ready && dump_addr == 9) begin chk("beat9_new", dump_data, 32'h2); seen9++; end
      if (dump_done) got = 1;
      tick;
    end
    dump_start = 0;
    chk("bp_done", got, 1);
    chk("bp_wrote", wrote, 1);
    chk("beat9_once", seen9, 1);
    tick;
    // abort during beat 12
    dump_ready = 1; dump_start = 1; Rs1_addr = 3;
    tick;
    dump_start = 0; found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (dump_valid && dump_addr == 12) found = 1;
      else tick;
    end
    chk("reach_beat12", found, 1);
    #2 rst = 1;
    #1;
    chk("abort_valid", dump_valid, 0);
    chk("abort_busy", dump_busy, 0);
    chk("abort_entry", Rs1_data, 32'h0);
    tick;
    rst = 0;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      #2 if (dump_done) ndone++;
      tick;
    end
    chk("abort_no_done", ndone, 0);
    dump_start = 1;
    tick;
    dump_start = 0; got = 0;
    #2;
    chk("restart_addr", dump_addr, 0);
    chk("restart_data", dump_data, 0);
    for (int c = 0; c < 40 && !got; c++) begin
      #2 if (dump_done) got = 1;
      tick;
    end
    chk("restart_done", got, 1);
    tick;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_param_dump.md
Name: regfile_param_dump

Overview:
- Parametrised general-purpose register file for the single-cycle CPU datapath.
- Generalises the fixed 32x32 file: width, depth and hardwired-zero entry are configurable, and same-cycle write-to-read bypass is optional.
- Adds a handshaked dump sequencer that streams every entry (address and data) to the debug/display path, replacing per-register output wires.

Parameters:
DATA_W, 32, entry width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
ZERO_REG, 1, 1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
BYPASS, 1, 1: read ports return wt_data on a same-cycle write hit; 0: read ports return stored array contents only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
RegWrite  in  1  write enable
Rs1_addr  in  ADDR_W  read port 1 address
Rs2_addr  in  ADDR_W  read port 2 address
Wt_addr  in  ADDR_W  write address
Wt_data  in  DATA_W  write data
Rs1_data  out  DATA_W  read port 1 data, combinational
Rs2_data  out  DATA_W  read port 2 data, combinational
dump_start  in  1  pulse to begin a dump; honoured only in IDLE
dump_ready  in  1  sink accepts the current beat
dump_valid  out  1  dump beat valid
dump_addr  out  ADDR_W  address of the current beat
dump_data  out  DATA_W  data of the current beat
dump_busy  out  1  high whenever FSM is not in IDLE
dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: asynchronous and active-high.
  - All entries clear to 0.
  - FSM goes to IDLE; dump index goes to 0.
  - dump_valid, dump_busy and dump_done go to 0; dump_addr and dump_data go to 0.
  - Asserting rst mid-dump aborts the dump; no dump_done is produced.
- Write: on the rising clk edge when RegWrite=1, entry[Wt_addr] takes Wt_data.
  - When ZERO_REG=1 and Wt_addr=0, the write is dropped.
- Read: combinational.
  - ZERO_REG=1 and addr=0: returns 0.
  - Otherwise, BYPASS=1 and RegWrite=1 and addr=Wt_addr (and the write is not dropped): returns Wt_data.
  - Otherwise: returns entry[addr].
  - Both ports may read the same address at once.
- Dump FSM states: IDLE, STREAM, DONE.
  - IDLE -> STREAM: on dump_start=1. dump_addr and dump_data load entry 0 at that edge; dump_valid rises the next cycle.
  - STREAM: dump_valid=1. dump_addr and dump_data are registered and held stable while dump_ready=0.
  - Beat transfer: dump_valid && dump_ready at a clock edge.
  - On transfer with dump_addr < 2**ADDR_W-1: increment dump_addr and load the next entry; stay in STREAM. Back-to-back beats are allowed, one per cycle.
  - On transfer with dump_addr = 2**ADDR_W-1: go to DONE and drop dump_valid.
  - DONE: dump_done=1 for exactly one cycle, then IDLE. dump_busy is still 1 in DONE.
- Dump data loading:
  - Loaded data equals the value the entry holds after the same edge, so a write to that address in the same cycle supplies Wt_data (subject to the ZERO_REG drop).
  - Entry 0 dumps as 0 when ZERO_REG=1.
  - Writes to an entry already loaded or already sent do not alter dump_data.
- dump_start in STREAM or DONE: ignored; no restart and no queuing.
- Register writes and reads proceed normally during a dump; the dump never stalls the datapath.
- Beats per dump: exactly 2**ADDR_W. Minimum dump latency is 2**ADDR_W+2 cycles from dump_start to dump_done.

Test Plan:
- Reset/readback: assert rst, then write entry k with 32'hA5A5_0000+k for k=1..31, then read on both ports -> each read returns its value; Rs1_addr=0 returns 0; a write to address 0 followed by a read returns 0 (ZERO_REG=1).
- Bypass: RegWrite=1, Wt_addr=5, Wt_data=32'hDEAD_BEEF, Rs1_addr=Rs2_addr=5 in the same cycle -> both ports read 32'hDEAD_BEEF that cycle (BYPASS=1); with BYPASS=0 they read the old value, 0.
- Dump with constant ready: after preload, pulse dump_start with dump_ready=1 -> 32 consecutive beats with dump_addr 0..31 and matching data; dump_done pulses once at cycle 34 after start; dump_busy falls the following cycle.
- Backpressure: toggle dump_ready every other cycle and pulse dump_start mid-stream -> dump_addr and dump_data hold while ready=0; no beat is skipped or duplicated; the mid-stream dump_start has no effect.
- Concurrent write: while stalled on beat 7, write entry 7 := 1 and entry 9 := 2 -> beat 7 keeps its old data; beat 9 carries 2.
- Abort: assert rst during beat 12 -> dump_valid, dump_busy and all entries are 0 immediately; no dump_done; a later dump_start runs cleanly from address 0.
